// File: rtl/ov5640_gesture_area_top_pkg.sv
// Shared constants for the OV5640 capture / skin-detect pipeline:
// pixel widths, chroma coefficients, skin window defaults and latencies.
package ov5640_gesture_area_top_pkg;

  localparam int RGB565_W = 16;
  localparam int RGB888_W = 24;
  localparam int YC_LAT   = 3;
  localparam int PIPE_LAT = 6;

  localparam int WAIT_FRAME_DEF = 10;
  localparam int CB_MIN_DEF     = 77;
  localparam int CB_MAX_DEF     = 127;
  localparam int CR_MIN_DEF     = 133;
  localparam int CR_MAX_DEF     = 173;

  // Chroma weights; both sums carry a +32768 bias so they stay unsigned.
  localparam logic [7:0]  CB_KR = 8'd43;
  localparam logic [7:0]  CB_KG = 8'd85;
  localparam logic [7:0]  CB_KB = 8'd128;
  localparam logic [7:0]  CR_KR = 8'd128;
  localparam logic [7:0]  CR_KG = 8'd107;
  localparam logic [7:0]  CR_KB = 8'd21;
  localparam logic [15:0] YC_OFFSET = 16'd32768;

  function automatic logic [RGB888_W-1:0] rgb565_to_888(input logic [RGB565_W-1:0] p);
    return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/ov5640_gesture_area_top_ycbcr_conv.sv
// Three-stage RGB888 -> Cb/Cr converter with a matched sideband delay for
// vsync, valid, ce and the original RGB. Luma is not consumed by the skin test.
module ov5640_gesture_area_top_ycbcr_conv
  import ov5640_gesture_area_top_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [RGB888_W-1:0] i_rgb,
  input  logic                i_ce,
  input  logic                i_vsync,
  input  logic                i_valid,
  output logic [7:0]          o_cb,
  output logic [7:0]          o_cr,
  output logic [RGB888_W-1:0] o_rgb,
  output logic                o_ce,
  output logic                o_vsync,
  output logic                o_valid
);

  logic [7:0]  w_r, w_g, w_b;
  logic [15:0] r_r_cb, r_g_cb, r_b_cb;
  logic [15:0] r_r_cr, r_g_cr, r_b_cr;
  logic [15:0] r_cb_sum, r_cr_sum;
  logic [7:0]  r_cb, r_cr;
  logic [YC_LAT-1:0] r_ce_sr, r_vs_sr, r_hs_sr;
  logic [YC_LAT-1:0][RGB888_W-1:0] r_rgb_sr;

  assign w_r = i_rgb[23:16];
  assign w_g = i_rgb[15:8];
  assign w_b = i_rgb[7:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_r_cb   <= '0;
      r_g_cb   <= '0;
      r_b_cb   <= '0;
      r_r_cr   <= '0;
      r_g_cr   <= '0;
      r_b_cr   <= '0;
      r_cb_sum <= '0;
      r_cr_sum <= '0;
      r_cb     <= '0;
      r_cr     <= '0;
      r_ce_sr  <= '0;
      r_vs_sr  <= '0;
      r_hs_sr  <= '0;
      r_rgb_sr <= '0;
    end else begin
      r_r_cb   <= 16'(w_r) * 16'(CB_KR);
      r_g_cb   <= 16'(w_g) * 16'(CB_KG);
      r_b_cb   <= 16'(w_b) * 16'(CB_KB);
      r_r_cr   <= 16'(w_r) * 16'(CR_KR);
      r_g_cr   <= 16'(w_g) * 16'(CR_KG);
      r_b_cr   <= 16'(w_b) * 16'(CR_KB);
      // Positive side plus bias first, so the subtraction never wraps.
      r_cb_sum <= (r_b_cb + YC_OFFSET) - (r_r_cb + r_g_cb);
      r_cr_sum <= (r_r_cr + YC_OFFSET) - (r_g_cr + r_b_cr);
      r_cb     <= r_cb_sum[15:8];
      r_cr     <= r_cr_sum[15:8];
      r_ce_sr  <= {r_ce_sr[YC_LAT-2:0], i_ce};
      r_vs_sr  <= {r_vs_sr[YC_LAT-2:0], i_vsync};
      r_hs_sr  <= {r_hs_sr[YC_LAT-2:0], i_valid};
      r_rgb_sr <= {r_rgb_sr[YC_LAT-2:0], i_rgb};
    end
  end

  assign o_cb    = r_cb;
  assign o_cr    = r_cr;
  assign o_rgb   = r_rgb_sr[YC_LAT-1];
  assign o_ce    = r_ce_sr[YC_LAT-1];
  assign o_vsync = r_vs_sr[YC_LAT-1];
  assign o_valid = r_hs_sr[YC_LAT-1];

endmodule

// File: rtl/ov5640_gesture_area_top.sv
// OV5640 DVP capture: frame skip after reset, RGB565 byte pairing, YCbCr
// conversion and fixed Cb/Cr skin masking. Six register stages end to end.
module ov5640_gesture_area_top
  import ov5640_gesture_area_top_pkg::*;
#(
  parameter int WAIT_FRAME = WAIT_FRAME_DEF,
  parameter int CB_MIN     = CB_MIN_DEF,
  parameter int CB_MAX     = CB_MAX_DEF,
  parameter int CR_MIN     = CR_MIN_DEF,
  parameter int CR_MAX     = CR_MAX_DEF
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        cam_rst_n,
  output logic        cam_pwdn,
  output logic        out_vsync,
  output logic        out_clken,
  output logic        out_valid,
  output logic [23:0] out_data
);

  localparam int CNT_W = $clog2(WAIT_FRAME + 1);

  logic             r_vs_d0, r_hs_d0, r_vs_d1;
  logic [7:0]       r_data_d0;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_frame_gate;
  logic             r_byte_flag;
  logic [7:0]       r_byte_hi;
  logic [RGB888_W-1:0] r_pix_rgb;
  logic             r_pix_ce, r_pix_vs, r_pix_hs;
  logic             r_out_vs, r_out_ce, r_out_hs;
  logic [RGB888_W-1:0] r_out_data;

  logic             w_vs_rise, w_frame_ok, w_second;
  logic [7:0]       w_cb, w_cr;
  logic [RGB888_W-1:0] w_yc_rgb;
  logic             w_yc_ce, w_yc_vs, w_yc_hs, w_skin;

  assign cam_rst_n  = 1'b1;
  assign cam_pwdn   = 1'b0;
  assign w_vs_rise  = r_vs_d0 & ~r_vs_d1;
  assign w_frame_ok = (r_frame_cnt == CNT_W'(WAIT_FRAME));
  assign w_second   = r_hs_d0 & r_byte_flag;

  // The gate is latched at each frame start, so a frame is passed whole or not at all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d0      <= 1'b0;
      r_hs_d0      <= 1'b0;
      r_data_d0    <= '0;
      r_vs_d1      <= 1'b0;
      r_frame_cnt  <= '0;
      r_frame_gate <= 1'b0;
      r_byte_flag  <= 1'b0;
      r_byte_hi    <= '0;
      r_pix_rgb    <= '0;
      r_pix_ce     <= 1'b0;
      r_pix_vs     <= 1'b0;
      r_pix_hs     <= 1'b0;
    end else begin
      r_vs_d0   <= cam_vsync;
      r_hs_d0   <= cam_href;
      r_data_d0 <= cam_data;
      r_vs_d1   <= r_vs_d0;
      if (w_vs_rise) begin
        r_frame_gate <= w_frame_ok;
        if (!w_frame_ok) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      r_byte_flag <= r_hs_d0 ? ~r_byte_flag : 1'b0;
      if (r_hs_d0 && !r_byte_flag) r_byte_hi <= r_data_d0;
      if (w_second) r_pix_rgb <= rgb565_to_888({r_byte_hi, r_data_d0});
      r_pix_ce <= w_second;
      r_pix_vs <= r_vs_d0;
      r_pix_hs <= r_hs_d0;
    end
  end

  ov5640_gesture_area_top_ycbcr_conv u_ycbcr (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_rgb   (r_pix_rgb),
    .i_ce    (r_pix_ce),
    .i_vsync (r_pix_vs),
    .i_valid (r_pix_hs),
    .o_cb    (w_cb),
    .o_cr    (w_cr),
    .o_rgb   (w_yc_rgb),
    .o_ce    (w_yc_ce),
    .o_vsync (w_yc_vs),
    .o_valid (w_yc_hs)
  );

  assign w_skin = (w_cb >= 8'(CB_MIN)) && (w_cb <= 8'(CB_MAX)) &&
                  (w_cr >= 8'(CR_MIN)) && (w_cr <= 8'(CR_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vs   <= 1'b0;
      r_out_ce   <= 1'b0;
      r_out_hs   <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_vs   <= w_yc_vs & r_frame_gate;
      r_out_ce   <= w_yc_ce & r_frame_gate;
      r_out_hs   <= w_yc_hs & r_frame_gate;
      r_out_data <= w_skin ? w_yc_rgb : '0;
    end
  end

  assign out_vsync = r_out_vs;
  assign out_clken = r_out_ce;
  assign out_valid = r_out_hs;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_ov5640_gesture_area_top.sv
// Directed bench for ov5640_gesture_area_top: frame skip, pixel latency,
// skin masking, odd-length lines and mid-frame reset.
module tb_ov5640_gesture_area_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        cam_rst_n, cam_pwdn;
  logic        out_vsync, out_clken, out_valid;
  logic [23:0] out_data;

  int n_checks = 0;
  int n_errs   = 0;

  // Output monitor, sampled on the falling edge.
  logic mon_clr = 1'b1;
  int   mon_ce = 0, mon_vs = 0, mon_hs = 0, mon_viol = 0, mon_cur = 0;
  logic mon_prev_ce = 1'b0, mon_prev_valid = 1'b0;
  int   line_q[$];

  logic [7:0]  px_hi  [4] = '{8'hE5, 8'hFF, 8'hF8, 8'h00};
  logic [7:0]  px_lo  [4] = '{8'h10, 8'hFF, 8'h00, 8'h00};
  logic [23:0] px_exp [4] = '{24'hE0A080, 24'h000000, 24'h000000, 24'h000000};

  always #5 clk = ~clk;

  ov5640_gesture_area_top dut (
    .clk       (clk),
    .rst       (rst),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .cam_rst_n (cam_rst_n),
    .cam_pwdn  (cam_pwdn),
    .out_vsync (out_vsync),
    .out_clken (out_clken),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always @(negedge clk) begin
    if (mon_clr) begin
      mon_ce   <= 0;
      mon_vs   <= 0;
      mon_hs   <= 0;
      mon_viol <= 0;
      mon_cur  <= 0;
      line_q.delete();
    end else begin
      if (out_clken) mon_ce <= mon_ce + 1;
      if (out_clken && mon_prev_ce) mon_viol <= mon_viol + 1;
      if (out_vsync) mon_vs <= mon_vs + 1;
      if (out_valid) mon_hs <= mon_hs + 1;
      if (out_valid && out_clken) mon_cur <= mon_cur + 1;
      if (mon_prev_valid && !out_valid) begin
        line_q.push_back(mon_cur);
        mon_cur <= 0;
      end
    end
    mon_prev_ce    <= out_clken;
    mon_prev_valid <= out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic send_line(input int nbytes, input int seed);
    cam_href = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      cam_data = 8'(b * 7 + seed);
      tick();
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (10) tick();
  endtask

  task automatic send_frame(input int rows, input int nbytes);
    cam_vsync = 1'b1;
    repeat (4) tick();
    for (int r = 0; r < rows; r++) send_line(nbytes, r);
    cam_vsync = 1'b0;
    repeat (20) tick();
  endtask

  // Output is checked 6 cycles after the low byte is driven, and not at 5.
  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo,
                            input logic [23:0] exp, input int idx);
    cam_href = 1'b1;
    cam_data = hi;
    tick();
    cam_data = lo;
    tick();
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (4) tick();
    chk($sformatf("px%0d_early_clken", idx), 32'(out_clken), 32'd0);
    tick();
    chk($sformatf("px%0d_clken", idx), 32'(out_clken), 32'd1);
    chk($sformatf("px%0d_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("px%0d_data", idx), 32'(out_data), 32'(exp));
    tick();
    chk($sformatf("px%0d_clken_after", idx), 32'(out_clken), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    // Reset
    rst       = 1'b1;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    repeat (3) tick();
    chk("rst_vsync", 32'(out_vsync), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_clken", 32'(out_clken), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("cam_rst_n", 32'(cam_rst_n), 32'd1);
    chk("cam_pwdn", 32'(cam_pwdn), 32'd0);
    rst = 1'b0;
    mon_clr = 1'b0;

    // Frames 1..10 are discarded
    for (int f = 0; f < 10; f++) send_frame(11, 60);
    chk("skip_vsync_cnt", 32'(mon_vs), 32'd0);
    chk("skip_valid_cnt", 32'(mon_hs), 32'd0);
    chk("skip_clken_cnt", 32'(mon_ce), 32'd0);

    // Frame 11 passes: 30 pixels per 60-byte line
    clear_mon();
    send_frame(11, 60);
    chk("f11_lines", 32'(line_q.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("f11_line%0d_pix", i), 32'(line_q[i]), 32'd30);
    chk("f11_vsync_seen", 32'(mon_vs != 0), 32'd1);
    chk("f11_clken_spacing", 32'(mon_viol), 32'd0);

    // Frame 12: vsync latency, directed pixels
    cam_vsync = 1'b1;
    repeat (5) tick();
    chk("vsync_lag5", 32'(out_vsync), 32'd0);
    tick();
    chk("vsync_lag6", 32'(out_vsync), 32'd1);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) send_pixel(px_hi[i], px_lo[i], px_exp[i], i);

    // Odd-length line drops its trailing byte; next line re-pairs
    clear_mon();
    send_line(61, 3);
    chk("odd_lines", 32'(line_q.size()), 32'd1);
    chk("odd_line_pix", 32'(line_q[0]), 32'd30);
    send_pixel(8'hE5, 8'h10, 24'hE0A080, 4);

    // Reset mid-line
    cam_href = 1'b1;
    for (int b = 0; b < 8; b++) begin
      cam_data = 8'hE5 ^ 8'(b);
      tick();
    end
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_vsync", 32'(out_vsync), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_clken", 32'(out_clken), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    clear_mon();
    repeat (20) tick();
    cam_href = 1'b0;
    repeat (10) tick();
    send_line(60, 1);
    send_line(60, 2);
    cam_vsync = 1'b0;
    repeat (20) tick();

    // Partial frame 12 counted once; frames 13..21 still discarded
    for (int f = 0; f < 9; f++) send_frame(11, 60);
    chk("post_rst_vsync_cnt", 32'(mon_vs), 32'd0);
    chk("post_rst_valid_cnt", 32'(mon_hs), 32'd0);
    chk("post_rst_clken_cnt", 32'(mon_ce), 32'd0);

    clear_mon();
    send_frame(11, 60);
    chk("f22_lines", 32'(line_q.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("f22_line%0d_pix", i), 32'(line_q[i]), 32'd30);
    chk("f22_clken_spacing", 32'(mon_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
